// File: rtl/requant_pc_pkg.sv
// Shared types and helpers for the per-channel requantization pipeline.
package requant_pc_pkg;

  typedef struct packed {
    logic [31:0] m0;
    logic [4:0]  shift;
    logic [15:0] zw;
  } cfg_entry_t;

  localparam int Q31 = 31;

  // Half of the final divisor 2^(Q31+shift), giving round-half-up after the arithmetic shift.
  function automatic logic [63:0] round_offset(input logic [4:0] shift);
    return 64'(1) << (Q31 - 1 + int'(shift));
  endfunction

endpackage

// File: rtl/requant_cfg_rf.sv
// Per-channel requantization config storage: one write port, one combinational read port.
module requant_cfg_rf
  import requant_pc_pkg::*;
#(
  parameter int CH   = 16,
  parameter int CH_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  cfg_entry_t      wdata,
  input  logic [CH_W-1:0] raddr,
  output cfg_entry_t      rdata
);

  cfg_entry_t mem [CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < CH)) begin
      mem[waddr] <= wdata;
    end
  end

  // The read returns pre-edge contents, so a same-cycle write is not seen by the reader.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < CH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/requant_pc.sv
// Four-stage per-channel requantizer: zero-point removal, Q31 scale, rounding shift, offset and clamp.
module requant_pc
  import requant_pc_pkg::*;
#(
  parameter  int ACC_W = 32,
  parameter  int OUT_W = 8,
  parameter  int CH    = 16,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [31:0]             cfg_m0,
  input  logic [4:0]              cfg_shift,
  input  logic [15:0]             cfg_zw,
  input  logic [OUT_W-1:0]        z3,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] serial32_in,
  input  logic signed [ACC_W-1:0] act_sum_in,
  input  logic [CH_W-1:0]         in_ch,
  output logic                    q_valid,
  input  logic                    q_ready,
  output logic [OUT_W-1:0]        q_out,
  output logic [CH_W-1:0]         q_ch
);

  localparam int PW = ACC_W + 32;
  localparam int VW = PW + 2;

  logic       en;
  cfg_entry_t wr_entry;
  cfg_entry_t rd_entry;

  logic                    s1_v;
  logic signed [ACC_W-1:0] s1_diff;
  logic signed [31:0]      s1_m0;
  logic [4:0]              s1_shift;
  logic [CH_W-1:0]         s1_ch;

  logic                    s2_v;
  logic signed [PW-1:0]    s2_prod;
  logic [4:0]              s2_shift;
  logic [CH_W-1:0]         s2_ch;

  logic                    s3_v;
  logic signed [PW:0]      s3_r;
  logic [CH_W-1:0]         s3_ch;

  logic signed [ACC_W-1:0] diff_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [PW:0]      off_c;
  logic signed [PW:0]      sum_c;
  logic signed [PW:0]      r_c;
  logic signed [VW-1:0]    v_c;
  logic signed [VW-1:0]    lo_c;
  logic signed [VW-1:0]    hi_c;
  logic [OUT_W-1:0]        sat_c;

  assign en       = !q_valid || q_ready;
  assign in_ready = en;
  assign wr_entry = '{m0: cfg_m0, shift: cfg_shift, zw: cfg_zw};

  requant_cfg_rf #(
    .CH   (CH),
    .CH_W (CH_W)
  ) u_cfg_rf (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_ch),
    .wdata (wr_entry),
    .raddr (in_ch),
    .rdata (rd_entry)
  );

  always_comb begin
    diff_c = serial32_in - ACC_W'($signed(rd_entry.zw)) * act_sum_in;
    prod_c = PW'(s1_diff) * PW'(s1_m0);
    off_c  = $signed({1'b0, PW'(round_offset(s2_shift))});
    sum_c  = (PW+1)'(s2_prod) + off_c;
    r_c    = sum_c >>> (7'(Q31) + 7'(s2_shift));
  end

  // Output stage works in a widened signed domain so huge positive or negative r cannot wrap before clamping.
  always_comb begin
    v_c   = VW'(s3_r) + VW'($signed({1'b0, z3}));
    lo_c  = relu_en ? VW'($signed({1'b0, z3})) : '0;
    hi_c  = VW'($signed({1'b0, {OUT_W{1'b1}}}));
    sat_c = v_c[OUT_W-1:0];
    if (v_c < lo_c) begin
      sat_c = lo_c[OUT_W-1:0];
    end else if (v_c > hi_c) begin
      sat_c = hi_c[OUT_W-1:0];
    end
  end

  // Whole pipeline advances together; a held output freezes every stage behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_diff  <= '0;
      s1_m0    <= '0;
      s1_shift <= '0;
      s1_ch    <= '0;
      s2_v     <= 1'b0;
      s2_prod  <= '0;
      s2_shift <= '0;
      s2_ch    <= '0;
      s3_v     <= 1'b0;
      s3_r     <= '0;
      s3_ch    <= '0;
      q_valid  <= 1'b0;
      q_out    <= '0;
      q_ch     <= '0;
    end else if (en) begin
      s1_v     <= in_valid;
      s1_diff  <= diff_c;
      s1_m0    <= $signed(rd_entry.m0);
      s1_shift <= rd_entry.shift;
      s1_ch    <= in_ch;
      s2_v     <= s1_v;
      s2_prod  <= prod_c;
      s2_shift <= s1_shift;
      s2_ch    <= s1_ch;
      s3_v     <= s2_v;
      s3_r     <= r_c;
      s3_ch    <= s2_ch;
      q_valid  <= s3_v;
      q_out    <= sat_c;
      q_ch     <= s3_ch;
    end
  end

endmodule

// File: tb/tb_requant_pc.sv
// Scoreboard bench for requant_pc: expected codes are queued at accept time and checked at output.
module tb_requant_pc;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [3:0]         cfg_ch;
  logic [31:0]        cfg_m0;
  logic [4:0]         cfg_shift;
  logic [15:0]        cfg_zw;
  logic [7:0]         z3;
  logic               relu_en;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] serial32_in;
  logic signed [31:0] act_sum_in;
  logic [3:0]         in_ch;
  logic               q_valid;
  logic               q_ready;
  logic [7:0]         q_out;
  logic [3:0]         q_ch;

  typedef struct {
    int q;
    int ch;
    int cyc;
    bit chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b1;
  bit   stream_done;
  bit   stall_prev = 1'b0;
  logic [7:0] held_out;
  logic [3:0] held_ch;
  int   m_m0 [16];
  int   m_shift [16];
  int   m_zw [16];

  requant_pc #(
    .ACC_W (32),
    .OUT_W (8),
    .CH    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_m0      (cfg_m0),
    .cfg_shift   (cfg_shift),
    .cfg_zw      (cfg_zw),
    .z3          (z3),
    .relu_en     (relu_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .serial32_in (serial32_in),
    .act_sum_in  (act_sum_in),
    .in_ch       (in_ch),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_out       (q_out),
    .q_ch        (q_ch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int model(input longint serial, input longint act, input int m0,
                               input int shift, input int zw, input int zp, input bit relu);
    int     diff;
    longint prod;
    longint r;
    longint v;
    longint lo;
    diff = int'(serial - longint'(zw) * act);
    prod = longint'(diff) * longint'(m0);
    r    = (prod + (longint'(1) << (30 + shift))) >>> (31 + shift);
    v    = r + zp;
    lo   = relu ? zp : 0;
    if (v < lo) v = lo;
    if (v > 255) v = 255;
    return int'(v);
  endfunction

  // Output side: pop on every transfer, and hold-stability whenever the previous cycle was stalled.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && q_valid) begin
        checkOutput("stable_q_out", q_out, held_out);
        checkOutput("stable_q_ch", q_ch, held_ch);
      end
      if (q_valid && q_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", q_valid, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("q_out", q_out, e.q);
          checkOutput("q_ch", q_ch, e.ch);
          if (e.chk_lat) checkOutput("latency", cyc - e.cyc, 4);
        end
      end
      stall_prev = q_valid && !q_ready;
      held_out   = q_out;
      held_ch    = q_ch;
    end
  end

  task automatic writeCfg(input int ch, input int m0, input int shift, input int zw);
    cfg_we    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_m0    = 32'(m0);
    cfg_shift = 5'(shift);
    cfg_zw    = 16'(zw);
    @(posedge clk);
    #1;
    cfg_we     = 1'b0;
    m_m0[ch]    = m0;
    m_shift[ch] = shift;
    m_zw[ch]    = zw;
  endtask

  task automatic applyStimulus(input int serial, input int act, input int ch, input int exp_q);
    bit ok;
    ok          = 1'b0;
    in_valid    = 1'b1;
    serial32_in = serial;
    act_sum_in  = act;
    in_ch       = 4'(ch);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{q: exp_q, ch: ch, cyc: cyc, chk_lat: lat_mode});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  function automatic int modelBeat(input int serial, input int act, input int ch);
    return model(serial, act, m_m0[ch], m_shift[ch], m_zw[ch], int'(z3), relu_en);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_m0[i] = 0; m_shift[i] = 0; m_zw[i] = 0;
    end
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_m0 = '0; cfg_shift = '0; cfg_zw = '0;
    z3 = 8'd0; relu_en = 1'b0; in_valid = 1'b0; serial32_in = '0; act_sum_in = '0;
    in_ch = '0; q_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_q_valid", q_valid, 0);
    checkOutput("rst_q_out", q_out, 0);
    checkOutput("rst_q_ch", q_ch, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    writeCfg(3, 1333811370, 7, 133);
    applyStimulus(20000, 10, 3, 91);
    waitDrain();
    applyStimulus(0, 10, 3, 0);
    waitDrain();
    z3 = 8'd128;
    applyStimulus(0, 10, 3, 122);
    waitDrain();
    relu_en = 1'b1;
    applyStimulus(0, 10, 3, 128);
    waitDrain();
    relu_en = 1'b0;
    z3 = 8'd0;
    applyStimulus(100000, 10, 3, 255);
    applyStimulus(-100000, 10, 3, 0);
    waitDrain();

    for (int i = 0; i < 16; i++) begin
      writeCfg(i, 1073741824 + i * 50000000, i % 8, i * 7);
    end
    z3 = 8'd17;
    lat_mode = 1'b0;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          applyStimulus(i * 3000 - 20000, i + 1, i, modelBeat(i * 3000 - 20000, i + 1, i));
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          q_ready = ~q_ready;
        end
      end
    join
    q_ready = 1'b1;
    waitDrain();
    lat_mode = 1'b1;
    z3 = 8'd0;

    // Config write lands on the same edge that accepts a beat for that channel.
    writeCfg(3, 1333811370, 7, 133);
    in_valid = 1'b1; serial32_in = 20000; act_sum_in = 10; in_ch = 4'd3;
    cfg_we = 1'b1; cfg_ch = 4'd3; cfg_m0 = 32'd0; cfg_shift = 5'd7; cfg_zw = 16'd133;
    @(negedge clk);
    checkOutput("same_cycle_ready", in_ready, 1);
    if (in_ready) sb.push_back('{q: 91, ch: 3, cyc: cyc, chk_lat: 1'b1});
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    in_valid = 1'b0;
    m_m0[3] = 0;
    applyStimulus(20000, 10, 3, 0);
    waitDrain();

    z3 = 8'd5;
    applyStimulus(20000, 10, 0, modelBeat(20000, 10, 0));
    applyStimulus(30000, 10, 0, modelBeat(30000, 10, 0));
    applyStimulus(40000, 10, 0, modelBeat(40000, 10, 0));
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_q_valid", q_valid, 0);
    checkOutput("midrst_q_out", q_out, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_m0[i] = 0; m_shift[i] = 0; m_zw[i] = 0;
    end
    @(negedge clk);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(20000, 10, 3, 5);
    applyStimulus(-7000, 3, 0, 5);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
